// File: rtl/store_write_buffer.sv
// Posted-write buffer between the CPU data-memory port and a slower memory bus.
// CPU stores are captured in one cycle into a DEPTH-entry FIFO and drained over
// a valid/ready handshake, so the CPU never stalls. Loads read mem_rdata.
// Optional store-to-load forwarding is enabled by defining WB_FWD_EN.
module store_write_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 32,
    parameter int DW    = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     cpu_we,
    input  logic [AW-1:0]            cpu_addr,
    input  logic [DW-1:0]            cpu_wdata,
    output logic [DW-1:0]            cpu_rdata,
    input  logic [DW-1:0]            mem_rdata,
    output logic                     bus_valid,
    output logic [AW-1:0]            bus_addr,
    output logic [DW-1:0]            bus_wdata,
    input  logic                     bus_ready,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     fwd_hit
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [AW-1:0] addr_q [DEPTH];
    logic [DW-1:0] data_q [DEPTH];

    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;

    logic          push;
    logic          pop;

    // Status flags and head-of-queue presentation come straight from registers.
    always_comb begin
        empty     = (count_q == '0);
        full      = (count_q == CW'(DEPTH));
        count     = count_q;
        overflow  = overflow_q;
        bus_valid = !empty;
        bus_addr  = addr_q[rd_ptr_q];
        bus_wdata = data_q[rd_ptr_q];
    end

    // Handshake decode: a pop frees a slot, so a store at full is accepted alongside it.
    always_comb begin
        pop  = bus_valid & bus_ready;
        push = cpu_we & (!full | pop);
    end

    // Next-state for pointers, occupancy and the sticky drop flag.
    always_comb begin
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        overflow_d = overflow_q;
        count_d    = count_q + CW'(push) - CW'(pop);
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (cpu_we && full && !pop) begin
            overflow_d = 1'b1;
        end
    end

    // Control state register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Entry storage; not cleared by reset since pointers define validity.
    always_ff @(posedge clk) begin
        if (reset && push) begin
            addr_q[wr_ptr_q] <= cpu_addr;
            data_q[wr_ptr_q] <= cpu_wdata;
        end
    end

`ifdef WB_FWD_EN
    // Forwarding: scan occupied entries oldest to youngest so the youngest match wins.
    always_comb begin
        logic [PW-1:0] idx;
        idx       = '0;
        cpu_rdata = mem_rdata;
        fwd_hit   = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            idx = rd_ptr_q + PW'(i);
            if ((CW'(i) < count_q) && (addr_q[idx][AW-1:2] == cpu_addr[AW-1:2])) begin
                cpu_rdata = data_q[idx];
                fwd_hit   = 1'b1;
            end
        end
    end
`else
    // No forwarding: loads always come from memory.
    always_comb begin
        cpu_rdata = mem_rdata;
        fwd_hit   = 1'b0;
    end
`endif

endmodule

// File: tb/tb_store_write_buffer.sv
// Self-checking bench for store_write_buffer (DEPTH=4, AW=DW=32).
// Honors WB_FWD_EN the same way as the design.
module tb_store_write_buffer;

    localparam int DEPTH = 4;
    localparam int AW    = 32;
    localparam int DW    = 32;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } ent_t;

    logic          clk;
    logic          reset;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic [DW-1:0] cpu_rdata;
    logic [DW-1:0] mem_rdata;
    logic          bus_valid;
    logic [AW-1:0] bus_addr;
    logic [DW-1:0] bus_wdata;
    logic          bus_ready;
    logic          full;
    logic          empty;
    logic [2:0]    count;
    logic          overflow;
    logic          fwd_hit;

    int   n_checks;
    int   n_fail;
    ent_t sb[$];
    logic ovf_m;

    store_write_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk       (clk),
        .reset     (reset),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .mem_rdata (mem_rdata),
        .bus_valid (bus_valid),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_ready (bus_ready),
        .full      (full),
        .empty     (empty),
        .count     (count),
        .overflow  (overflow),
        .fwd_hit   (fwd_hit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Expected load data from the model queue: youngest word-address match wins.
    function automatic logic [DW:0] fwd_model(input logic [AW-1:0] addr, input logic [DW-1:0] mem);
        logic [DW:0] r;
        r = {1'b0, mem};
`ifdef WB_FWD_EN
        foreach (sb[i]) begin
            if (sb[i].a[AW-1:2] == addr[AW-1:2]) r = {1'b1, sb[i].d};
        end
`endif
        return r;
    endfunction

    // One clock cycle: drive, check combinational outputs at negedge, update model, advance.
    task automatic cycle(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input logic rdy);
        logic [DW:0] fm;
        ent_t        e;
        logic        mpop;
        cpu_we    = we;
        cpu_addr  = a;
        cpu_wdata = d;
        bus_ready = rdy;
        @(negedge clk);
        check_eq("count",     64'(count),     64'(sb.size()));
        check_eq("bus_valid", 64'(bus_valid), 64'(sb.size() != 0));
        check_eq("full",      64'(full),      64'(sb.size() == DEPTH));
        check_eq("empty",     64'(empty),     64'(sb.size() == 0));
        check_eq("overflow",  64'(overflow),  64'(ovf_m));
        fm = fwd_model(a, mem_rdata);
        check_eq("cpu_rdata", 64'(cpu_rdata), 64'(fm[DW-1:0]));
        check_eq("fwd_hit",   64'(fwd_hit),   64'(fm[DW]));
        mpop = (sb.size() != 0) && rdy;
        if (mpop) begin
            e = sb.pop_front();
            check_eq("bus_addr",  64'(bus_addr),  64'(e.a));
            check_eq("bus_wdata", 64'(bus_wdata), 64'(e.d));
        end
        if (we) begin
            if (sb.size() < DEPTH) sb.push_back('{a: a, d: d});
            else ovf_m = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset  = 1'b0;
        cpu_we = 1'b0;
        bus_ready = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        sb.delete();
        ovf_m = 1'b0;
        check_eq("rst_count",     64'(count),     64'd0);
        check_eq("rst_empty",     64'(empty),     64'd1);
        check_eq("rst_full",      64'(full),      64'd0);
        check_eq("rst_bus_valid", 64'(bus_valid), 64'd0);
        check_eq("rst_overflow",  64'(overflow),  64'd0);
        check_eq("rst_fwd_hit",   64'(fwd_hit),   64'd0);
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        ovf_m     = 1'b0;
        reset     = 1'b0;
        cpu_we    = 1'b0;
        cpu_addr  = '0;
        cpu_wdata = '0;
        bus_ready = 1'b0;
        mem_rdata = 32'h0000_BEEF;
        @(posedge clk);
        #1;
        do_reset();
        cycle(1'b0, 32'h0, 32'h0, 1'b0);

        // Push without drain, then drain two in order.
        cycle(1'b1, 32'h100, 32'hAAAA_0001, 1'b0);
        cycle(1'b1, 32'h104, 32'hAAAA_0002, 1'b0);
        check_eq("two_count", 64'(count), 64'd2);
        cycle(1'b0, 32'h0, 32'h0, 1'b1);
        cycle(1'b0, 32'h0, 32'h0, 1'b1);
        check_eq("two_empty", 64'(empty), 64'd1);

        // Fill and drop.
        for (int i = 0; i < 5; i++) cycle(1'b1, 32'h10 + 32'(4*i), 32'hC000_0000 + 32'(i), 1'b0);
        check_eq("fill_full",     64'(full),     64'd1);
        check_eq("fill_overflow", 64'(overflow), 64'd1);
        for (int i = 0; i < 4; i++) cycle(1'b0, 32'h0, 32'h0, 1'b1);
        check_eq("fill_drained", 64'(empty), 64'd1);

        // Simultaneous push/pop at full.
        for (int i = 0; i < 4; i++) cycle(1'b1, 32'h40 + 32'(4*i), 32'hD000_0000 + 32'(i), 1'b0);
        cycle(1'b1, 32'h200, 32'h55, 1'b1);
        check_eq("pp_count",    64'(count),    64'd4);
        check_eq("pp_head",     64'(bus_addr), 64'h44);
        check_eq("pp_overflow", 64'(overflow), 64'd1);
        for (int i = 0; i < 4; i++) cycle(1'b0, 32'h0, 32'h0, 1'b1);
        check_eq("pp_drained", 64'(empty), 64'd1);

        // Wrap-around with random back-pressure.
        do_reset();
        for (int i = 0; i < 10; i++)
            cycle(1'b1, 32'h1000 + 32'(4*i), $urandom, 1'($urandom_range(0, 1)));
        for (int i = 0; i < 20 && sb.size() != 0; i++) cycle(1'b0, 32'h0, 32'h0, 1'b1);
        check_eq("wrap_empty", 64'(empty), 64'd1);

        // Forwarding.
        mem_rdata = 32'hDEAD;
        cycle(1'b1, 32'h300, 32'h11, 1'b0);
        cycle(1'b1, 32'h300, 32'h22, 1'b0);
        cpu_we   = 1'b0;
        cpu_addr = 32'h302;
        #1;
`ifdef WB_FWD_EN
        check_eq("fwd_data",  64'(cpu_rdata), 64'h22);
        check_eq("fwd_hit1",  64'(fwd_hit),   64'd1);
`else
        check_eq("fwd_data",  64'(cpu_rdata), 64'hDEAD);
        check_eq("fwd_hit1",  64'(fwd_hit),   64'd0);
`endif
        cpu_addr = 32'h304;
        #1;
        check_eq("nofwd_data", 64'(cpu_rdata), 64'hDEAD);
        check_eq("nofwd_hit",  64'(fwd_hit),   64'd0);
        cycle(1'b0, 32'h302, 32'h0, 1'b0);

        // Reset mid-drain discards buffered entries.
        cycle(1'b0, 32'h0, 32'h0, 1'b1);
        do_reset();
        cycle(1'b0, 32'h0, 32'h0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
